// File: rtl/mnist_lut_pkg.sv
// Shared constants and network description for the binary LUT-network MNIST classifier.
// The connection and truth-table generators below stand in for the training tool's
// output: every node's wiring and 64-bit table is a pure function of (layer, node).
package mnist_lut_pkg;

    localparam int N_LAYERS  = 4;
    localparam int LUT_K     = 6;
    localparam int LUT_SIZE  = 1 << LUT_K;
    localparam int LATENCY   = 4;
    localparam int MAX_WIDTH = 1024;

    // Index 0 is the pixel input, index L+1 is the output of layer L.
    localparam int LAYER_WIDTH [N_LAYERS+1] = '{784, 1024, 360, 60, 10};

    // Odd prime, coprime with every layer width, so the wiring permutes the
    // previous layer and every previous-layer bit feeds at least one node.
    localparam int          CONN_STRIDE = 7919;
    localparam logic [63:0] TABLE_SEED  = 64'h5A17_C0DE_0B1E_F00D;

    function automatic logic [63:0] mix64(input logic [63:0] x);
        logic [63:0] z;
        z = x + 64'h9E37_79B9_7F4A_7C15;
        z = (z ^ (z >> 30)) * 64'hBF58_476D_1CE4_E5B9;
        z = (z ^ (z >> 27)) * 64'h94D0_49BB_1331_11EB;
        return z ^ (z >> 31);
    endfunction

    // CONN[layer][node][k]: previous-layer bit driving input k of the node.
    function automatic int lut_conn(input int layer, input int node, input int k);
        int in_w;
        int out_w;
        in_w  = LAYER_WIDTH[layer];
        out_w = LAYER_WIDTH[layer+1];
        return ((node + k * out_w) * CONN_STRIDE + 13 * layer) % in_w;
    endfunction

    // TABLE[layer][node]: 64-entry truth table, addressed by {c5..c0}.
    function automatic logic [LUT_SIZE-1:0] lut_table(input int layer, input int node);
        return mix64({layer, node} ^ TABLE_SEED);
    endfunction

endpackage

// File: rtl/lut_layer.sv
// One layer of 6-input LUT nodes followed by a single clock-enabled, sync-reset register.
module lut_layer
    import mnist_lut_pkg::*;
#(
    parameter int LAYER = 0,
    parameter int IN_W  = 784,
    parameter int OUT_W = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cke,
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    logic [OUT_W-1:0] w_lut;
    logic [OUT_W-1:0] r_data;

    for (genvar j = 0; j < OUT_W; j++) begin : g_node
        localparam logic [LUT_SIZE-1:0] TBL = lut_table(LAYER, j);
        logic [LUT_K-1:0] w_idx;

        for (genvar k = 0; k < LUT_K; k++) begin : g_in
            localparam int SRC = lut_conn(LAYER, j, k);
            assign w_idx[k] = i_data[SRC];
        end

        assign w_lut[j] = TBL[w_idx];
    end

    // Layer output register: cleared by reset regardless of cke, otherwise advances on cke.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (cke) begin
            r_data <= w_lut;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/mnist_simple_lut_mlp.sv
// Fully pipelined 784 -> 1024 -> 360 -> 60 -> 10 binary LUT network, one sample per
// enabled cycle, four-cycle latency, with valid and user tag carried alongside.
module mnist_simple_lut_mlp
    import mnist_lut_pkg::*;
#(
    parameter int USER_WIDTH   = 0,
    parameter int INPUT_WIDTH  = 784,
    parameter int OUTPUT_WIDTH = 10
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cke,
    input  logic [(USER_WIDTH > 0 ? USER_WIDTH : 1)-1:0] in_user,
    input  logic [INPUT_WIDTH-1:0]                     in_data,
    input  logic                                       in_valid,
    output logic [(USER_WIDTH > 0 ? USER_WIDTH : 1)-1:0] out_user,
    output logic [OUTPUT_WIDTH-1:0]                    out_data,
    output logic                                       out_valid
);

    localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;

    logic [LAYER_WIDTH[1]-1:0] w_l0;
    logic [LAYER_WIDTH[2]-1:0] w_l1;
    logic [LAYER_WIDTH[3]-1:0] w_l2;
    logic [OUTPUT_WIDTH-1:0]   w_l3;

    logic [LATENCY-1:0] r_valid;
    logic [UW-1:0]      r_user [LATENCY];

    lut_layer #(.LAYER(0), .IN_W(INPUT_WIDTH),    .OUT_W(LAYER_WIDTH[1])) u_layer0 (
        .clk(clk), .reset(reset), .cke(cke), .i_data(in_data), .o_data(w_l0)
    );
    lut_layer #(.LAYER(1), .IN_W(LAYER_WIDTH[1]), .OUT_W(LAYER_WIDTH[2])) u_layer1 (
        .clk(clk), .reset(reset), .cke(cke), .i_data(w_l0), .o_data(w_l1)
    );
    lut_layer #(.LAYER(2), .IN_W(LAYER_WIDTH[2]), .OUT_W(LAYER_WIDTH[3])) u_layer2 (
        .clk(clk), .reset(reset), .cke(cke), .i_data(w_l1), .o_data(w_l2)
    );
    lut_layer #(.LAYER(3), .IN_W(LAYER_WIDTH[3]), .OUT_W(OUTPUT_WIDTH))   u_layer3 (
        .clk(clk), .reset(reset), .cke(cke), .i_data(w_l2), .o_data(w_l3)
    );

    // Valid/user delay line, one stage per layer so it stays aligned with the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_user[i] <= '0;
            end
        end else if (cke) begin
            r_valid   <= {r_valid[LATENCY-2:0], in_valid};
            r_user[0] <= in_user;
            for (int i = 1; i < LATENCY; i++) begin
                r_user[i] <= r_user[i-1];
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign out_user  = r_user[LATENCY-1];
    assign out_data  = w_l3;

endmodule

// File: tb/tb_mnist_simple_lut_mlp.sv
// Self-checking bench: a high-level reference (layer-by-layer evaluation of the
// package tables plus a "sample from four enabled edges ago" rule) is compared
// against the DUT every cycle, with directed timing checks on top.
module tb_mnist_simple_lut_mlp;
    import mnist_lut_pkg::*;

    localparam int UW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           cke;
    logic [UW-1:0]  in_user;
    logic [783:0]   in_data;
    logic           in_valid;
    logic [UW-1:0]  out_user;
    logic [9:0]     out_data;
    logic           out_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          v;
        logic [UW-1:0] u;
        logic [9:0]    d;
    } exp_t;

    exp_t hist[$];
    int   since_rst;
    bit   counting;
    int   model_matches;
    int   dut_matches;

    int          tconn [N_LAYERS][MAX_WIDTH][LUT_K];
    logic [63:0] ttab  [N_LAYERS][MAX_WIDTH];

    mnist_simple_lut_mlp #(.USER_WIDTH(UW), .INPUT_WIDTH(784), .OUTPUT_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
        .out_user(out_user), .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] golden(input logic [783:0] img);
        bit         cur [MAX_WIDTH];
        bit         nxt [MAX_WIDTH];
        int         idx;
        logic [9:0] res;
        for (int i = 0; i < MAX_WIDTH; i++) cur[i] = 1'b0;
        for (int i = 0; i < 784; i++) cur[i] = img[i];
        for (int l = 0; l < N_LAYERS; l++) begin
            for (int j = 0; j < LAYER_WIDTH[l+1]; j++) begin
                idx = 0;
                for (int k = 0; k < LUT_K; k++) if (cur[tconn[l][j][k]]) idx += (1 << k);
                nxt[j] = ttab[l][j][idx];
            end
            for (int j = 0; j < LAYER_WIDTH[l+1]; j++) cur[j] = nxt[j];
        end
        for (int k = 0; k < 10; k++) res[k] = cur[k];
        return res;
    endfunction

    function automatic logic [783:0] rand_img();
        logic [783:0] img;
        for (int i = 0; i < 24; i++) img[i*32 +: 32] = $urandom;
        img[783:768] = 16'($urandom);
        return img;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (hist.size() == LATENCY) begin
            e = hist[0];
            chk("out_valid", 64'(out_valid), 64'(e.v));
            chk("out_user",  64'(out_user),  64'(e.u));
            chk("out_data",  64'(out_data),  64'(e.d));
        end else begin
            chk("out_valid_fill", 64'(out_valid), 64'd0);
            chk("out_user_fill",  64'(out_user),  64'd0);
            if (since_rst == 0) chk("out_data_reset", 64'(out_data), 64'd0);
        end
        if (counting && out_valid === 1'b1 && out_user < 10 && out_data === (10'd1 << out_user))
            dut_matches++;
    endtask

    // One clock: drive inputs, take the edge, advance the reference, compare.
    task automatic cycle(input logic rst, input logic ce, input logic v,
                         input logic [UW-1:0] u, input logic [783:0] d);
        exp_t e;
        reset = rst; cke = ce; in_valid = v; in_user = u; in_data = d;
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            since_rst = 0;
        end else if (ce) begin
            e.v = v; e.u = u; e.d = golden(d);
            if (counting && v && e.d == (10'd1 << u)) model_matches++;
            hist.push_back(e);
            if (hist.size() > LATENCY) void'(hist.pop_front());
            since_rst++;
        end
        check_out();
    endtask

    initial begin
        int            lat;
        int            nv;
        logic [UW-1:0] seen_user;
        logic [9:0]    cap0, cap1;
        logic [UW-1:0] users[$];
        int            first_v, last_v;
        logic [UW-1:0] lbl;

        for (int l = 0; l < N_LAYERS; l++)
            for (int j = 0; j < LAYER_WIDTH[l+1]; j++) begin
                ttab[l][j] = lut_table(l, j);
                for (int k = 0; k < LUT_K; k++) tconn[l][j][k] = lut_conn(l, j, k);
            end
        since_rst = 0; counting = 0; model_matches = 0; dut_matches = 0;

        // Reset held 100 cycles with valid toggling and cke random.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'(i % 2), UW'($urandom), rand_img());

        // Single tagged sample: one valid pulse, four cycles later.
        lat = 0; nv = 0; seen_user = '0;
        cycle(1'b0, 1'b1, 1'b1, 8'h07, rand_img());
        if (out_valid === 1'b1) begin nv++; lat = 1; end
        for (int n = 2; n <= 8; n++) begin
            cycle(1'b0, 1'b1, 1'b0, UW'($urandom), rand_img());
            if (out_valid === 1'b1) begin
                nv++;
                if (lat == 0) lat = n;
                seen_user = out_user;
            end
        end
        chk("latency", 64'(lat), 64'd4);
        chk("valid_pulse_count", 64'(nv), 64'd1);
        chk("passthrough_user", 64'(seen_user), 64'h07);

        // All-zero and all-ones images.
        cap0 = 'x; cap1 = 'x;
        cycle(1'b0, 1'b1, 1'b1, 8'hA0, '0);
        cycle(1'b0, 1'b1, 1'b1, 8'hA1, '1);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, rand_img());
            if (out_valid === 1'b1 && out_user == 8'hA0) cap0 = out_data;
            if (out_valid === 1'b1 && out_user == 8'hA1) cap1 = out_data;
        end
        chk("golden_zeros", 64'(cap0), 64'(golden('0)));
        chk("golden_ones",  64'(cap1), 64'(golden('1)));

        // cke dropped for 5 cycles with three samples in flight.
        users.delete(); first_v = 0; last_v = 0;
        for (int n = 1; n <= 16; n++) begin
            if (n <= 3)      cycle(1'b0, 1'b1, 1'b1, UW'(8'h10 + n), rand_img());
            else if (n <= 8) cycle(1'b0, 1'b0, 1'b1, 8'hEE, rand_img());
            else             cycle(1'b0, 1'b1, 1'b0, 8'h00, rand_img());
            if (out_valid === 1'b1) begin
                users.push_back(out_user);
                if (first_v == 0) first_v = n;
                last_v = n;
            end
        end
        chk("cke_out_count", 64'(users.size()), 64'd3);
        for (int i = 0; i < users.size() && i < 3; i++)
            chk("cke_order", 64'(users[i]), 64'(8'h11 + i));
        chk("cke_first_out", 64'(first_v), 64'd9);
        chk("cke_last_out",  64'(last_v),  64'd11);

        // Mid-stream reset: four samples discarded, then a fresh one at latency 4.
        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b1, UW'(8'h30 + n), rand_img());
        cycle(1'b1, 1'b1, 1'b1, 8'h33, rand_img());
        nv = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 1'b1, 1'b0, UW'($urandom), rand_img());
            if (out_valid === 1'b1) nv++;
        end
        chk("reset_discard", 64'(nv), 64'd0);
        lat = 0; seen_user = '0;
        cycle(1'b0, 1'b1, 1'b1, 8'h55, rand_img());
        for (int n = 2; n <= 7; n++) begin
            cycle(1'b0, 1'b1, 1'b0, UW'($urandom), rand_img());
            if (out_valid === 1'b1 && lat == 0) begin lat = n; seen_user = out_user; end
        end
        chk("post_reset_latency", 64'(lat), 64'd4);
        chk("post_reset_user", 64'(seen_user), 64'h55);

        // Back-to-back random stream with user = label.
        counting = 1;
        for (int n = 0; n < 2000; n++) begin
            lbl = UW'($urandom_range(0, 9));
            cycle(1'b0, 1'b1, 1'b1, lbl, rand_img());
        end
        for (int n = 0; n < 4; n++) cycle(1'b0, 1'b1, 1'b0, 8'h00, rand_img());
        counting = 0;
        chk("stream_match_count", 64'(dut_matches), 64'(model_matches));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mnist_simple_lut_mlp.md
Name: mnist_simple_lut_mlp

Overview:
Fully pipelined binary LUT-network classifier for MNIST. Takes one binarized 28x28 image (784 bits) per clock and produces a 10-bit class vector, with an opaque user tag carried alongside. Sits between the image binarizer/stream source and the result checker/argmax stage. One sample is accepted every enabled cycle; there is no backpressure.

Parameters:
USER_WIDTH, 0, width of the sideband tag passed through unchanged; 0 means no tag; the top-level bench uses 8.
INPUT_WIDTH, 784, input pixel bits; fixed, not overridable in practice.
OUTPUT_WIDTH, 10, class output bits; fixed.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cke  in  1  clock enable; when 0 the whole pipeline holds state.
in_user  in  USER_WIDTH (min 1)  sideband tag, typically the label.
in_data  in  784  binarized pixels; bit (y*28+x), 1 = ink.
in_valid  in  1  sample qualifier.
out_user  out  USER_WIDTH (min 1)  delayed in_user.
out_data  out  10  class vector; bit k set = network votes class k.
out_valid  out  1  delayed in_valid.

Behaviour:
- Network: 4 cascaded layers of 6-input LUTs, widths 784 -> 1024 -> 360 -> 60 -> 10.
- Each LUT node j of layer L:
  - selects 6 inputs from the previous layer via connection table CONN[L][j][0..5];
  - forms idx = {in[c5],...,in[c0]}, with c0 as the LSB;
  - outputs TABLE[L][j][idx] from a 64-bit truth table.
- Tables and connections are generated by the training tool and live in the package; RTL must not hard-code them.
- Each layer output is registered. There is no input register. Latency is exactly 4 cycles from in_* to out_*.
- in_user and in_valid travel in a 4-stage shift register, aligned with the data.
- Register update occurs only when cke=1. With cke=0 all stages, including valid and user, hold.
- Reset (synchronous, while reset=1 at a rising clk edge, regardless of cke):
  - all valid stages clear to 0;
  - all data and user stages clear to 0;
  - so out_valid=0, out_data=0 and out_user=0 hold from the first reset edge.
- Reset asserted mid-stream discards all in-flight samples. After release, the first valid output appears 4 enabled cycles after the first sampled in_valid=1.
- Data is computed regardless of in_valid. X on in_data while in_valid=0 may propagate into data stages but never into valid stages.
- out_data is the raw layer-3 output. It is not forced one-hot; zero or multiple bits may be set.
- Correct classification is defined as out_valid && out_data == (1 << label).
- Throughput is 1 sample/cycle; back-to-back valids are fully supported.

Decomposition:
- Package mnist_lut_pkg holds:
  - N_LAYERS=4 and the LAYER_WIDTH array;
  - LUT_K=6 and LATENCY=4;
  - per-layer CONN and TABLE constant arrays, generated.
- Sub-module lut_layer (params IN_W, OUT_W, CONN, TABLE):
  - generate loop of OUT_W 6-input LUTs feeding one cke-gated, sync-reset register;
  - instantiated 4 times by the top, which adds the valid/user delay line.

Test Plan:
- Reset: hold reset=1 for 100 cycles with in_valid toggling -> out_valid=0, out_data=0, out_user=0 throughout.
- Latency/passthrough: after reset, drive one sample with in_user=8'h07 and in_valid=1 for 1 cycle -> out_valid=1 for exactly 1 cycle, 4 cycles later, with out_user=8'h07.
- Golden compare: all-zero image and all-ones image -> out_data bit-exact with the package-driven software model for both, at latency 4.
- cke hold: stream 3 samples and drop cke for 5 cycles mid-flight -> outputs freeze, then resume in order with no loss or duplication; total span 3+4+5 cycles.
- Streaming: 10000 mnist_test vectors back-to-back, user=label -> every out_data matches the golden model per sample; match count equals the model's reported accuracy count.
- Mid-stream reset: assert reset for 1 cycle while 4 samples are in flight -> none of them emerge; next sample emerges 4 cycles after it is presented.
